// File: rtl/fft_frame_scheduler_if.sv
// Handshake/bus bundle between the FFT frame scheduler and its neighbours
// (read path, streaming FFT core, write requestor and control).
interface fft_frame_scheduler_if #(
  parameter int unsigned DATA_W = 512,
  parameter int unsigned CNT_W  = 32
);
  logic              enable;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              core_next_in;
  logic [DATA_W-1:0] core_data_in;
  logic              core_next_out;
  logic [DATA_W-1:0] core_data_out;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic              idle;
  logic [CNT_W-1:0]  frames_done;
  logic              err;

  modport master (
    output enable, in_valid, in_data, core_next_out, core_data_out, out_ready,
    input  in_ready, core_next_in, core_data_in, out_valid, out_data, idle, frames_done, err
  );

  modport slave (
    input  enable, in_valid, in_data, core_next_out, core_data_out, out_ready,
    output in_ready, core_next_in, core_data_in, out_valid, out_data, idle, frames_done, err
  );
endinterface

// File: rtl/fft_frame_scheduler.sv
// Feeds whole frames from an input FIFO into a non-stallable streaming FFT core and
// captures its output frames into an output FIFO, launching only with guaranteed room.
module fft_frame_scheduler #(
  parameter int unsigned DATA_W      = 512,
  parameter int unsigned FRAME_WORDS = 4,
  parameter int unsigned IN_DEPTH    = 8,
  parameter int unsigned OUT_DEPTH   = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  fft_frame_scheduler_if.slave  bus
);

  localparam int unsigned IN_AW  = $clog2(IN_DEPTH);
  localparam int unsigned IN_CW  = $clog2(IN_DEPTH + 1);
  localparam int unsigned OUT_AW = $clog2(OUT_DEPTH);
  localparam int unsigned OUT_CW = $clog2(OUT_DEPTH + 1);
  localparam int unsigned FW_LG  = $clog2(FRAME_WORDS);
  localparam int unsigned INF_W  = $clog2(OUT_DEPTH / FRAME_WORDS + 2);
  localparam int unsigned CR_W   = OUT_CW + INF_W + FW_LG + 2;

  typedef enum logic [1:0] {IDLE, LAUNCH, STREAM} launch_state_t;
  typedef enum logic       {CAP_IDLE, CAP}        cap_state_t;

  launch_state_t state_q, state_d;
  cap_state_t    cap_q, cap_d;
  logic [FW_LG-1:0] str_cnt_q, str_cnt_d;
  logic [FW_LG-1:0] cap_cnt_q, cap_cnt_d;
  logic [INF_W-1:0] inflight_q, inflight_d;

  logic [DATA_W-1:0] in_mem_q [IN_DEPTH];
  logic [IN_AW-1:0]  in_wr_q, in_wr_d, in_rd_q, in_rd_d;
  logic [IN_CW-1:0]  in_count_q, in_count_d;

  logic [DATA_W-1:0] out_mem_q [OUT_DEPTH];
  logic [OUT_AW-1:0] out_wr_q, out_wr_d, out_rd_q, out_rd_d;
  logic [OUT_CW-1:0] out_count_q, out_count_d;

  logic              in_ready_q, in_ready_d;
  logic              core_next_in_q, core_next_in_d;
  logic [DATA_W-1:0] core_data_in_q, core_data_in_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              idle_q, idle_d;
  logic [CNT_W-1:0]  frames_done_q, frames_done_d;
  logic              err_q, err_d;

  logic             in_push, in_pop;
  logic             cap_push, cap_done, out_push, out_pop, out_full;
  logic             err_set, launch_ok, credit_ok;
  logic [IN_CW-1:0] in_avail;
  logic [CR_W-1:0]  cap_rem, out_used;

  // Launch gating: words left after this cycle's pop, and worst-case output occupancy
  always_comb begin
    in_push   = bus.in_valid & in_ready_q;
    in_pop    = (state_q == STREAM);
    in_avail  = in_count_q - IN_CW'(in_pop);
    cap_rem   = (cap_q == CAP) ? (CR_W'(FRAME_WORDS) - CR_W'(cap_cnt_q)) : '0;
    out_used  = CR_W'(out_count_q) + (CR_W'(inflight_q) << FW_LG) + cap_rem;
    credit_ok = (out_used + CR_W'(FRAME_WORDS)) <= CR_W'(OUT_DEPTH);
    launch_ok = bus.enable && (in_avail >= IN_CW'(FRAME_WORDS)) && credit_ok;
  end

  // Launch FSM next state
  always_comb begin
    state_d   = state_q;
    str_cnt_d = str_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (launch_ok) state_d = LAUNCH;
      end
      LAUNCH: begin
        state_d   = STREAM;
        str_cnt_d = '0;
      end
      STREAM: begin
        str_cnt_d = str_cnt_q + FW_LG'(1);
        if (str_cnt_q == FW_LG'(FRAME_WORDS - 1)) state_d = launch_ok ? LAUNCH : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture FSM next state and protocol error detection
  always_comb begin
    cap_d     = cap_q;
    cap_cnt_d = cap_cnt_q;
    cap_done  = 1'b0;
    err_set   = 1'b0;
    unique case (cap_q)
      CAP_IDLE: begin
        if (bus.core_next_out) begin
          if (inflight_q == '0) begin
            err_set = 1'b1;
          end else begin
            cap_d     = CAP;
            cap_cnt_d = '0;
          end
        end
      end
      CAP: begin
        cap_cnt_d = cap_cnt_q + FW_LG'(1);
        if (cap_cnt_q == FW_LG'(FRAME_WORDS - 1)) begin
          cap_done = 1'b1;
          cap_d    = CAP_IDLE;
          // back-to-back frame: the next frame must already be counted in flight
          if (bus.core_next_out) begin
            if (inflight_q > INF_W'(1)) begin
              cap_d     = CAP;
              cap_cnt_d = '0;
            end else begin
              err_set = 1'b1;
            end
          end
        end else if (bus.core_next_out) begin
          err_set = 1'b1;
        end
      end
      default: cap_d = CAP_IDLE;
    endcase
  end

  // FIFO bookkeeping and registered output values
  always_comb begin
    cap_push = (cap_q == CAP);
    out_pop  = out_valid_q & bus.out_ready;
    out_full = (out_count_q == OUT_CW'(OUT_DEPTH));
    out_push = cap_push & (~out_full | out_pop);

    in_wr_d    = in_wr_q + IN_AW'(in_push);
    in_rd_d    = in_rd_q + IN_AW'(in_pop);
    in_count_d = in_count_q + IN_CW'(in_push) - IN_CW'(in_pop);

    out_wr_d    = out_wr_q + OUT_AW'(out_push);
    out_rd_d    = out_rd_q + OUT_AW'(out_pop);
    out_count_d = out_count_q + OUT_CW'(out_push) - OUT_CW'(out_pop);

    inflight_d    = inflight_q + INF_W'(state_q == LAUNCH) - INF_W'(cap_done);
    frames_done_d = frames_done_q + CNT_W'(cap_done);
    err_d         = err_q | err_set | (cap_push & ~out_push);

    in_ready_d     = (in_count_d < IN_CW'(IN_DEPTH));
    core_next_in_d = (state_d == LAUNCH);
    core_data_in_d = (state_d == STREAM) ? in_mem_q[in_rd_d] : '0;

    out_valid_d = (out_count_d != '0);
    out_data_d  = '0;
    if (out_count_d != '0) begin
      // a word landing in an empty FIFO becomes the head immediately
      if (out_push && (out_wr_q == out_rd_d)) out_data_d = bus.core_data_out;
      else                                    out_data_d = out_mem_q[out_rd_d];
    end

    idle_d = (state_d == IDLE) && (cap_d == CAP_IDLE) && (inflight_d == '0) &&
             (in_count_d == '0) && (out_count_d == '0);
  end

  // Storage arrays: contents only meaningful under the FIFO counts
  always_ff @(posedge clk) begin
    if (in_push)  in_mem_q[in_wr_q]   <= bus.in_data;
    if (out_push) out_mem_q[out_wr_q] <= bus.core_data_out;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      cap_q          <= CAP_IDLE;
      str_cnt_q      <= '0;
      cap_cnt_q      <= '0;
      inflight_q     <= '0;
      in_wr_q        <= '0;
      in_rd_q        <= '0;
      in_count_q     <= '0;
      out_wr_q       <= '0;
      out_rd_q       <= '0;
      out_count_q    <= '0;
      in_ready_q     <= 1'b0;
      core_next_in_q <= 1'b0;
      core_data_in_q <= '0;
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      idle_q         <= 1'b1;
      frames_done_q  <= '0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      cap_q          <= cap_d;
      str_cnt_q      <= str_cnt_d;
      cap_cnt_q      <= cap_cnt_d;
      inflight_q     <= inflight_d;
      in_wr_q        <= in_wr_d;
      in_rd_q        <= in_rd_d;
      in_count_q     <= in_count_d;
      out_wr_q       <= out_wr_d;
      out_rd_q       <= out_rd_d;
      out_count_q    <= out_count_d;
      in_ready_q     <= in_ready_d;
      core_next_in_q <= core_next_in_d;
      core_data_in_q <= core_data_in_d;
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
      idle_q         <= idle_d;
      frames_done_q  <= frames_done_d;
      err_q          <= err_d;
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.core_next_in = core_next_in_q;
  assign bus.core_data_in = core_data_in_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = out_data_q;
  assign bus.idle         = idle_q;
  assign bus.frames_done  = frames_done_q;
  assign bus.err          = err_q;

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Bench for fft_frame_scheduler: a fixed-latency FFT core model (output = ~input) plus
// a transaction-level reference (output stream = transformed input stream, whole frames).
module tb_fft_frame_scheduler;
  localparam int unsigned DATA_W = 512;
  localparam int unsigned FW     = 4;
  localparam int unsigned CNT_W  = 32;
  localparam int          LAT    = 10;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fft_frame_scheduler_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  fft_frame_scheduler #(
    .DATA_W(DATA_W), .FRAME_WORDS(FW), .IN_DEPTH(8), .OUT_DEPTH(16), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int checks = 0;
  int passed = 0;

  int cyc = 0;
  int collect = 0;
  int core_words = 0;
  int nin_q[$];
  logic [DATA_W-1:0] sent_q[$];
  logic [DATA_W-1:0] got_q[$];
  bit                nxt_at[int];
  logic [DATA_W-1:0] dat_at[int];

  // Core model and output monitor, sampled mid-cycle after all drivers have settled
  initial begin
    bus.core_next_out = 1'b0;
    bus.core_data_out = '0;
    forever begin
      @(posedge clk); #3;
      cyc++;
      if (!reset) begin
        if (bus.core_next_in) begin
          nin_q.push_back(cyc);
          nxt_at[cyc + LAT] = 1'b1;
          collect = FW;
        end else if (collect > 0) begin
          dat_at[cyc + LAT] = ~bus.core_data_in;
          core_words++;
          collect--;
        end
        if (bus.out_valid && bus.out_ready) got_q.push_back(bus.out_data);
      end
      bus.core_next_out = nxt_at.exists(cyc);
      bus.core_data_out = dat_at.exists(cyc) ? dat_at[cyc] : '0;
    end
  end

  function automatic logic [DATA_W-1:0] rand_word();
    logic [DATA_W-1:0] w;
    for (int i = 0; i < DATA_W / 32; i++) w[i*32 +: 32] = $urandom();
    return w;
  endfunction

  task automatic clear_model();
    nxt_at.delete();
    dat_at.delete();
    got_q.delete();
    sent_q.delete();
    nin_q.delete();
    collect = 0;
    core_words = 0;
  endtask

  task automatic do_reset();
    bus.enable = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    #1 reset = 1'b1;
    clear_model();
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic push_word(input logic [DATA_W-1:0] w);
    bit acc;
    int n;
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    n = 0;
    do begin
      acc = bus.in_ready;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 3000);
    bus.in_valid = 1'b0;
    if (acc) sent_q.push_back(w);
    else begin
      checks++;
      $display("FAIL push_timeout: in_ready stayed 0 for %0d cycles, required acceptance", n);
    end
  endtask

  task automatic wait_frames(input int frames, input int bound);
    int n = 0;
    while (!(bus.frames_done == CNT_W'(frames) && bus.idle) && n < bound) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.enable = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    #1 reset = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); else passed++;
    checks++; if (bus.core_next_in !== 1'b0) $display("FAIL rst_next_in: got %b want 0", bus.core_next_in); else passed++;
    checks++; if (bus.core_data_in !== '0) $display("FAIL rst_core_data_in: got %h want 0", bus.core_data_in); else passed++;
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); else passed++;
    checks++; if (bus.out_data !== '0) $display("FAIL rst_out_data: got %h want 0", bus.out_data); else passed++;
    checks++; if (bus.idle !== 1'b1) $display("FAIL rst_idle: got %b want 1", bus.idle); else passed++;
    checks++; if (bus.frames_done !== '0) $display("FAIL rst_frames_done: got %0d want 0", bus.frames_done); else passed++;
    checks++; if (bus.err !== 1'b0) $display("FAIL rst_err: got %b want 0", bus.err); else passed++;
    @(posedge clk); #1;
    checks++; if (bus.in_ready !== 1'b0) $display("FAIL rst_in_ready_held: got %b want 0", bus.in_ready); else passed++;
    reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.in_ready !== 1'b1) $display("FAIL rst_in_ready_after: got %b want 1", bus.in_ready); else passed++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.enable = 1'b1; bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) push_word(rand_word());
    wait_frames(2, 300);
    checks++; if (nin_q.size() != 2) $display("FAIL b2b_launches: got %0d want 2", nin_q.size()); else passed++;
    checks++;
    if (nin_q.size() < 2 || nin_q[1] - nin_q[0] != FW + 1)
      $display("FAIL b2b_spacing: got %0d want %0d", nin_q.size() < 2 ? -1 : nin_q[1] - nin_q[0], FW + 1);
    else passed++;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== ~sent_q[i])
        $display("FAIL b2b_data[%0d]: got %h want %h", i, i < got_q.size() ? got_q[i] : '0, ~sent_q[i]);
      else passed++;
    end
    checks++; if (bus.frames_done !== 32'd2) $display("FAIL b2b_frames_done: got %0d want 2", bus.frames_done); else passed++;
    checks++; if (bus.idle !== 1'b1) $display("FAIL b2b_idle: got %b want 1", bus.idle); else passed++;
    checks++; if (bus.err !== 1'b0) $display("FAIL b2b_err: got %b want 0", bus.err); else passed++;
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.enable = 1'b1; bus.out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 24; i++) push_word(rand_word());
      end
    join_none
    repeat (150) @(posedge clk);
    #1;
    checks++; if (nin_q.size() != 4) $display("FAIL bp_launches: got %0d want 4", nin_q.size()); else passed++;
    checks++; if (bus.in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b want 0", bus.in_ready); else passed++;
    checks++; if (bus.frames_done !== 32'd4) $display("FAIL bp_frames_done: got %0d want 4", bus.frames_done); else passed++;
    checks++; if (bus.out_valid !== 1'b1) $display("FAIL bp_out_valid: got %b want 1", bus.out_valid); else passed++;
    bus.out_ready = 1'b1;
    wait fork;
    wait_frames(6, 600);
    checks++; if (nin_q.size() != 6) $display("FAIL bp_total_launches: got %0d want 6", nin_q.size()); else passed++;
    checks++; if (got_q.size() != 24) $display("FAIL bp_out_words: got %0d want 24", got_q.size()); else passed++;
    for (int i = 0; i < 24; i++) begin
      checks++;
      if (i >= got_q.size() || i >= sent_q.size() || got_q[i] !== ~sent_q[i])
        $display("FAIL bp_data[%0d]: got %h want %h", i, i < got_q.size() ? got_q[i] : '0,
                 i < sent_q.size() ? ~sent_q[i] : '0);
      else passed++;
    end
    checks++; if (bus.err !== 1'b0) $display("FAIL bp_err: got %b want 0", bus.err); else passed++;
  endtask

  task automatic test_partial_frame();
    logic [DATA_W-1:0] w;
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) push_word(rand_word());
    bus.enable = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checks++; if (nin_q.size() != 0) $display("FAIL part_no_launch: got %0d want 0", nin_q.size()); else passed++;
    w = rand_word();
    bus.in_valid = 1'b1; bus.in_data = w;
    checks++; if (bus.in_ready !== 1'b1) $display("FAIL part_in_ready: got %b want 1", bus.in_ready); else passed++;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    sent_q.push_back(w);
    checks++; if (bus.core_next_in !== 1'b0) $display("FAIL part_next_in_early: got %b want 0", bus.core_next_in); else passed++;
    @(posedge clk); #1;
    checks++; if (bus.core_next_in !== 1'b1) $display("FAIL part_next_in: got %b want 1", bus.core_next_in); else passed++;
    wait_frames(1, 200);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== ~sent_q[i])
        $display("FAIL part_data[%0d]: got %h want %h", i, i < got_q.size() ? got_q[i] : '0, ~sent_q[i]);
      else passed++;
    end
  endtask

  task automatic test_enable_drop();
    int n = 0;
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) push_word(rand_word());
    bus.enable = 1'b1;
    while (bus.core_next_in !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (bus.core_data_in !== sent_q[1]) $display("FAIL ed_word2: got %h want %h", bus.core_data_in, sent_q[1]); else passed++;
    bus.enable = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    checks++; if (nin_q.size() != 1) $display("FAIL ed_launches: got %0d want 1", nin_q.size()); else passed++;
    checks++; if (core_words != 4) $display("FAIL ed_core_words: got %0d want 4", core_words); else passed++;
    checks++; if (bus.frames_done !== 32'd1) $display("FAIL ed_frames_done: got %0d want 1", bus.frames_done); else passed++;
    checks++; if (bus.idle !== 1'b0) $display("FAIL ed_idle: got %b want 0", bus.idle); else passed++;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== ~sent_q[i])
        $display("FAIL ed_data[%0d]: got %h want %h", i, i < got_q.size() ? got_q[i] : '0, ~sent_q[i]);
      else passed++;
    end
  endtask

  task automatic test_spurious();
    do_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.err !== 1'b0) $display("FAIL sp_err_before: got %b want 0", bus.err); else passed++;
    nxt_at[cyc + 2] = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (bus.err !== 1'b1) $display("FAIL sp_err_set: got %b want 1", bus.err); else passed++;
    repeat (10) @(posedge clk);
    #1;
    checks++; if (bus.err !== 1'b1) $display("FAIL sp_err_sticky: got %b want 1", bus.err); else passed++;
    do_reset();
    checks++; if (bus.err !== 1'b0) $display("FAIL sp_err_cleared: got %b want 0", bus.err); else passed++;
  endtask

  task automatic test_reset_mid_cap();
    int n = 0;
    int t;
    do_reset();
    bus.enable = 1'b1; bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) push_word(rand_word());
    while (nin_q.size() == 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    t = (nin_q.size() > 0) ? nin_q[0] : cyc;
    n = 0;
    while (cyc < t + LAT + 2 && n < 100) begin
      @(posedge clk); #4;
      n++;
    end
    checks++; if (bus.out_valid !== 1'b1) $display("FAIL rm_out_valid_before: got %b want 1", bus.out_valid); else passed++;
    #1 reset = 1'b1;
    #1;
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL rm_out_valid: got %b want 0", bus.out_valid); else passed++;
    checks++; if (bus.out_data !== '0) $display("FAIL rm_out_data: got %h want 0", bus.out_data); else passed++;
    checks++; if (bus.idle !== 1'b1) $display("FAIL rm_idle: got %b want 1", bus.idle); else passed++;
    checks++; if (bus.in_ready !== 1'b0) $display("FAIL rm_in_ready: got %b want 0", bus.in_ready); else passed++;
    clear_model();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) push_word(rand_word());
    wait_frames(2, 300);
    checks++; if (bus.frames_done !== 32'd2) $display("FAIL rm_frames_done: got %0d want 2", bus.frames_done); else passed++;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== ~sent_q[i])
        $display("FAIL rm_data[%0d]: got %h want %h", i, i < got_q.size() ? got_q[i] : '0, ~sent_q[i]);
      else passed++;
    end
    checks++; if (bus.err !== 1'b0) $display("FAIL rm_err: got %b want 0", bus.err); else passed++;
  endtask

  task automatic test_random();
    int min_gap = 1000;
    do_reset();
    bus.enable = 1'b1;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          push_word(rand_word());
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #0;
        end
      end
      begin
        int n = 0;
        while (!(bus.frames_done == 32'd10 && bus.idle) && n < 5000) begin
          bus.out_ready = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
          n++;
        end
        bus.out_ready = 1'b1;
      end
    join
    repeat (3) @(posedge clk);
    #1;
    for (int i = 1; i < nin_q.size(); i++)
      if (nin_q[i] - nin_q[i-1] < min_gap) min_gap = nin_q[i] - nin_q[i-1];
    checks++; if (min_gap < FW + 1) $display("FAIL rnd_spacing: got %0d want >= %0d", min_gap, FW + 1); else passed++;
    checks++; if (got_q.size() != 40) $display("FAIL rnd_out_words: got %0d want 40", got_q.size()); else passed++;
    for (int i = 0; i < 40; i++) begin
      checks++;
      if (i >= got_q.size() || i >= sent_q.size() || got_q[i] !== ~sent_q[i])
        $display("FAIL rnd_data[%0d]: got %h want %h", i, i < got_q.size() ? got_q[i] : '0,
                 i < sent_q.size() ? ~sent_q[i] : '0);
      else passed++;
    end
    checks++; if (bus.frames_done !== 32'd10) $display("FAIL rnd_frames_done: got %0d want 10", bus.frames_done); else passed++;
    checks++; if (bus.idle !== 1'b1) $display("FAIL rnd_idle: got %b want 1", bus.idle); else passed++;
    checks++; if (bus.err !== 1'b0) $display("FAIL rnd_err: got %b want 0", bus.err); else passed++;
  endtask

  initial begin
    bus.enable = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_partial_frame();
    test_enable_drop();
    test_spurious();
    test_reset_mid_cap();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
